riscv_test_bus_arb: RTL and testbench



---
 rtl/riscv_test_bus_arb.sv | 161 ++++++++++++++++
 tb/tb_riscv_test_bus_arb.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_test_bus_arb.sv
// Registered test-bus arbiter: routes one paged memory port to either the host
// master or the core under test, with ack handshake, timeout, finish capture and a cycle counter.
module riscv_test_bus_arb #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int OFFSET_BITS    = 6,
  parameter int PAGE_BITS      = 6,
  parameter int FINISH_OFFSET  = 60,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  option,
  input  logic [PAGE_BITS-1:0]  memory_page_number,
  input  logic                  read,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  ready,
  input  logic                  core_read,
  input  logic                  core_write,
  input  logic [ADDR_WIDTH-1:0] core_address,
  input  logic [DATA_WIDTH-1:0] core_write_data,
  output logic [DATA_WIDTH-1:0] core_read_data,
  output logic                  core_ready,
  output logic                  memory_read,
  output logic                  memory_write,
  output logic [ADDR_WIDTH-1:0] memory_address,
  output logic [DATA_WIDTH-1:0] memory_write_data,
  input  logic [DATA_WIDTH-1:0] memory_read_data,
  input  logic                  memory_ack,
  output logic                  finish,
  output logic [DATA_WIDTH-1:0] finish_code,
  output logic [31:0]           cycle_count,
  output logic                  bus_error
);

  localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WAIT_W-1:0]      WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [OFFSET_BITS-1:0] FIN_OFS   = OFFSET_BITS'(FINISH_OFFSET);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state, next_state;

  logic              owner_core;   // owner latched in IDLE; option is ignored elsewhere
  logic              op_write;
  logic [WAIT_W-1:0] wait_cnt;

  logic                  sel_read, sel_write, sel_req;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [ADDR_WIDTH-1:0] mapped_addr;
  logic                  timeout;
  logic                  done;
  logic                  finish_hit;
  logic                  unused_addr_bits;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    sel_read   = option ? core_read       : read;
    sel_write  = option ? core_write      : write;
    sel_addr   = option ? core_address    : address;
    sel_wdata  = option ? core_write_data : write_data;
    sel_req    = sel_read | sel_write;
    timeout    = (wait_cnt == WAIT_LAST);
    done       = memory_ack | timeout;
    finish_hit = option & core_write & ~finish &
                 (core_address[OFFSET_BITS-1:0] == FIN_OFS);
    next_state = state;
    case (state)
      IDLE:    if (sel_req) next_state = ACCESS;
      ACCESS:  if (done)    next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Page prefix replaces everything above the in-page offset.
  assign mapped_addr = ADDR_WIDTH'({memory_page_number, sel_addr[OFFSET_BITS-1:0]});

  assign unused_addr_bits = ^{address[ADDR_WIDTH-1:OFFSET_BITS],
                              core_address[ADDR_WIDTH-1:OFFSET_BITS]};

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_core        <= 1'b0;
      op_write          <= 1'b0;
      wait_cnt          <= '0;
      memory_read       <= 1'b0;
      memory_write      <= 1'b0;
      memory_address    <= '0;
      memory_write_data <= '0;
      read_data         <= '0;
      core_read_data    <= '0;
      ready             <= 1'b0;
      core_ready        <= 1'b0;
      finish            <= 1'b0;
      finish_code       <= '0;
      bus_error         <= 1'b0;
    end else begin
      ready      <= 1'b0;
      core_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (sel_req) begin
            owner_core     <= option;
            op_write       <= sel_write;
            memory_write   <= sel_write;
            memory_read    <= ~sel_write;
            memory_address <= mapped_addr;
            wait_cnt       <= '0;
            if (sel_write) memory_write_data <= sel_wdata;
          end
          if (finish_hit) begin
            finish      <= 1'b1;
            finish_code <= core_write_data;
          end
        end
        ACCESS: begin
          if (done) begin
            memory_read  <= 1'b0;
            memory_write <= 1'b0;
            if (!memory_ack) bus_error <= 1'b1;
            // An aborted read returns zero rather than stale bus contents.
            if (!op_write) begin
              if (owner_core) core_read_data <= memory_ack ? memory_read_data : '0;
              else            read_data      <= memory_ack ? memory_read_data : '0;
            end
            ready      <= ~owner_core;
            core_ready <= owner_core;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Core-mode cycles up to and including the one whose write sets finish.
  always_ff @(posedge clk) begin
    if (reset)
      cycle_count <= '0;
    else if (option && !finish && cycle_count != 32'hFFFF_FFFF)
      cycle_count <= cycle_count + 32'd1;
  end

endmodule

// File: tb/tb_riscv_test_bus_arb.sv
// Directed scoreboard bench: stimulus pushes expected memory accesses and
// responses; a memory responder and a response monitor pop and compare.
module tb_riscv_test_bus_arb;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        option = 1'b0;
  logic [5:0]  memory_page_number = 6'd3;
  logic        read = 1'b0, write = 1'b0;
  logic [31:0] address = '0, write_data = '0, read_data;
  logic        ready;
  logic        core_read = 1'b0, core_write = 1'b0;
  logic [31:0] core_address = '0, core_write_data = '0, core_read_data;
  logic        core_ready;
  logic        memory_read, memory_write;
  logic [31:0] memory_address, memory_write_data;
  logic [31:0] memory_read_data = '0;
  logic        memory_ack = 1'b0;
  logic        finish;
  logic [31:0] finish_code, cycle_count;
  logic        bus_error;

  riscv_test_bus_arb #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .OFFSET_BITS(6), .PAGE_BITS(6),
    .FINISH_OFFSET(60), .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk), .reset(reset), .option(option),
    .memory_page_number(memory_page_number),
    .read(read), .write(write), .address(address), .write_data(write_data),
    .read_data(read_data), .ready(ready),
    .core_read(core_read), .core_write(core_write), .core_address(core_address),
    .core_write_data(core_write_data), .core_read_data(core_read_data),
    .core_ready(core_ready),
    .memory_read(memory_read), .memory_write(memory_write),
    .memory_address(memory_address), .memory_write_data(memory_write_data),
    .memory_read_data(memory_read_data), .memory_ack(memory_ack),
    .finish(finish), .finish_code(finish_code), .cycle_count(cycle_count),
    .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          core;
    bit          rd;
    logic [31:0] data;
    bit          berr;
  } rsp_t;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;   // strobe cycle carrying ack; 0 = never ack
  } mem_t;

  rsp_t rsp_q[$];
  mem_t mem_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   scnt = 0;
  int   cur_delay = 0;
  int   last_len = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // Memory model: checks each access on its first strobe cycle and acks on cue.
  always @(negedge clk) begin
    if (memory_read || memory_write) begin
      if (scnt == 0) begin
        if (mem_q.size() == 0) begin
          check("unexpected_mem_access", 32'd1, 32'd0);
          cur_delay = 1;
        end else begin
          mem_t e;
          e = mem_q.pop_front();
          check("mem_op_write", {31'd0, memory_write}, {31'd0, e.wr});
          check("mem_op_read",  {31'd0, memory_read},  {31'd0, !e.wr});
          check("mem_address", memory_address, e.addr);
          if (e.wr) check("mem_write_data", memory_write_data, e.wdata);
          memory_read_data = e.rdata;
          cur_delay = e.delay;
        end
      end
      scnt++;
      memory_ack = (cur_delay != 0) && (scnt == cur_delay);
    end else begin
      if (scnt != 0) last_len = scnt;
      scnt = 0;
      memory_ack = 1'b0;
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    if (ready || core_ready) begin
      if (rsp_q.size() == 0) begin
        check("unexpected_ready", {30'd0, ready, core_ready}, 32'd0);
      end else begin
        rsp_t e;
        e = rsp_q.pop_front();
        check("rsp_core_ready", {31'd0, core_ready}, {31'd0, e.core});
        check("rsp_master_ready", {31'd0, ready}, {31'd0, !e.core});
        if (e.rd) check("rsp_read_data", e.core ? core_read_data : read_data, e.data);
        check("rsp_bus_error", {31'd0, bus_error}, {31'd0, e.berr});
      end
    end
  end

  function automatic logic [31:0] maddr(input logic [31:0] a);
    return {20'd0, memory_page_number, a[5:0]};
  endfunction

  // Issue one request from the current negedge; returns negedges until its ready.
  task automatic req(input bit core, input bit wr, input logic [31:0] addr,
                     input logic [31:0] wdata, output int lat);
    if (core) begin
      core_address = addr; core_write_data = wdata;
      core_write = wr; core_read = !wr;
    end else begin
      address = addr; write_data = wdata;
      write = wr; read = !wr;
    end
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!(core ? core_ready : ready) && lat < 40);
    if (lat >= 40) check("ready_wait_expired", 32'd0, 32'd1);
    read = 1'b0; write = 1'b0; core_read = 1'b0; core_write = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int s;
    int n;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_strobes", {30'd0, memory_read, memory_write}, 32'd0);
    check("rst_address", memory_address, 32'd0);
    check("rst_wdata", memory_write_data, 32'd0);
    check("rst_read_data", read_data, 32'd0);
    check("rst_core_read_data", core_read_data, 32'd0);
    check("rst_flags", {28'd0, ready, core_ready, finish, bus_error}, 32'd0);
    check("rst_finish_code", finish_code, 32'd0);
    check("rst_cycle_count", cycle_count, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Master write, ack on third strobe cycle.
    mem_q.push_back('{1'b1, 32'h0000_00C5, 32'hDEAD_BEEF, 32'h0, 3});
    rsp_q.push_back('{1'b0, 1'b0, 32'h0, 1'b0});
    req(1'b0, 1'b1, 32'h0000_0005, 32'hDEAD_BEEF, lat);
    check("wr_latency", lat, 32'd4);
    @(negedge clk);
    check("wr_ready_drops", {31'd0, ready}, 32'd0);
    check("wr_strobe_len", last_len, 32'd3);
    check("wr_read_data_kept", read_data, 32'd0);

    // Master read, ack in first strobe cycle.
    mem_q.push_back('{1'b0, 32'h0000_00C5, 32'h0, 32'hDEAD_BEEF, 1});
    rsp_q.push_back('{1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0});
    req(1'b0, 1'b0, 32'hFFFF_FF05, 32'h0, lat);
    check("rd_latency", lat, 32'd2);
    @(negedge clk);
    check("rd_read_data_held", read_data, 32'hDEAD_BEEF);
    check("rd_core_read_data", core_read_data, 32'd0);

    // option flips to core during a master access; core waits for next IDLE.
    mem_q.push_back('{1'b0, 32'h0000_00CA, 32'h0, 32'h1111_2222, 3});
    rsp_q.push_back('{1'b0, 1'b1, 32'h1111_2222, 1'b0});
    mem_q.push_back('{1'b0, 32'h0000_00D1, 32'h0, 32'h3333_4444, 1});
    rsp_q.push_back('{1'b1, 1'b1, 32'h3333_4444, 1'b0});
    option = 1'b0; address = 32'h0000_000A; read = 1'b1;
    @(negedge clk);
    option = 1'b1; core_address = 32'h0000_0011; core_read = 1'b1;
    n = 0;
    while (!ready && n < 20) begin @(negedge clk); n++; end
    check("flip_master_served", {31'd0, ready}, 32'd1);
    read = 1'b0;
    n = 0;
    while (!core_ready && n < 20) begin @(negedge clk); n++; end
    check("flip_core_served", {31'd0, core_ready}, 32'd1);
    core_read = 1'b0;
    @(negedge clk);
    check("flip_master_data_kept", read_data, 32'h1111_2222);

    // Timeout: ack never arrives.
    option = 1'b0;
    mem_q.push_back('{1'b0, 32'h0000_00C7, 32'h0, 32'h0, 0});
    rsp_q.push_back('{1'b0, 1'b1, 32'h0, 1'b1});
    req(1'b0, 1'b0, 32'h0000_0007, 32'h0, lat);
    check("to_latency", lat, 32'd5);
    @(negedge clk);
    check("to_strobe_len", last_len, 32'd4);
    check("to_bus_error", {31'd0, bus_error}, 32'd1);

    // bus_error does not block further accesses.
    mem_q.push_back('{1'b1, 32'h0000_00FF, 32'h0BAD_F00D, 32'h0, 2});
    rsp_q.push_back('{1'b0, 1'b0, 32'h0, 1'b1});
    req(1'b0, 1'b1, 32'h0000_003F, 32'h0BAD_F00D, lat);
    check("post_err_latency", lat, 32'd3);
    @(negedge clk);

    // Reset in the middle of an access.
    mem_q.push_back('{1'b0, 32'h0000_00C7, 32'h0, 32'h0, 0});
    address = 32'h0000_0007; read = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("mid_rst_strobe_before", {31'd0, memory_read}, 32'd1);
    reset = 1'b1; read = 1'b0;
    @(negedge clk);
    check("mid_rst_strobes", {30'd0, memory_read, memory_write}, 32'd0);
    check("mid_rst_no_ready", {30'd0, ready, core_ready}, 32'd0);
    check("mid_rst_bus_error", {31'd0, bus_error}, 32'd0);

    // Core mode from reset release; finish write accepted on the 100th cycle.
    reset = 1'b0; option = 1'b1; s = cyc;
    mem_q.push_back('{1'b0, 32'h0000_00FC, 32'h0, 32'h5A5A_5A5A, 1});
    rsp_q.push_back('{1'b1, 1'b1, 32'h5A5A_5A5A, 1'b0});
    req(1'b1, 1'b0, 32'hABC0_003C, 32'h0, lat);
    check("fin_read_no_finish", {31'd0, finish}, 32'd0);
    n = 0;
    while (cyc < s + 99 && n < 200) begin @(negedge clk); n++; end
    mem_q.push_back('{1'b1, 32'h0000_00FC, 32'h0000_0001, 32'h0, 1});
    rsp_q.push_back('{1'b1, 1'b0, 32'h0, 1'b0});
    req(1'b1, 1'b1, 32'hABC0_003C, 32'h0000_0001, lat);
    check("fin_set", {31'd0, finish}, 32'd1);
    check("fin_code", finish_code, 32'h0000_0001);
    check("cycle_count_at_finish", cycle_count, 32'd100);
    repeat (5) @(negedge clk);
    check("cycle_count_frozen", cycle_count, 32'd100);

    mem_q.push_back('{1'b1, 32'h0000_00FC, 32'h0000_0002, 32'h0, 1});
    rsp_q.push_back('{1'b1, 1'b0, 32'h0, 1'b0});
    req(1'b1, 1'b1, 32'h0000_003C, 32'h0000_0002, lat);
    @(negedge clk);
    check("fin_code_held", finish_code, 32'h0000_0001);
    check("fin_still_set", {31'd0, finish}, 32'd1);
    check("core_read_data_held", core_read_data, 32'h5A5A_5A5A);

    repeat (3) @(negedge clk);
    check("rsp_queue_drained", rsp_q.size(), 32'd0);
    check("mem_queue_drained", mem_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
